led_mode_sw_cond: RTL



---
 rtl/led_pkg.sv | 26 ++
 rtl/sync_2ff.sv | 32 +++
 rtl/led_mode_sw_cond.sv | 121 ++++++++++++
 3 files changed

// File: rtl/led_pkg.sv
// Shared definitions for the LED pattern generator front end: mode codes,
// debounce FSM states and the board-clock timing defaults.
package led_pkg;

   localparam int SW_W_DEF = 4;

   localparam logic [3:0] MODE_SHIFT = 4'h0;
   localparam logic [3:0] MODE_SPLIT = 4'h1;
   localparam logic [3:0] MODE_FAST  = 4'h4;
   localparam logic [3:0] MODE_CLEAR = 4'hF;

   // 10 ms debounce and 0.1 s step period at the 100 MHz board clock
   localparam int DEBOUNCE_CYCLES_DEF = 1000000;
   localparam int TICK_DIV_DEF        = 10000000;

   typedef enum logic [0:0] {
      STABLE   = 1'b0,
      SETTLING = 1'b1
   } deb_state_e;

   // Width of a counter that runs 0 .. limit-1
   function automatic int cnt_w(input int limit);
      return (limit <= 2) ? 1 : $clog2(limit);
   endfunction

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchroniser for an asynchronous multi-bit bus; the bus is
// debounced as a whole vector downstream, so per-bit skew is tolerated.
module sync_2ff #(
   parameter int W = 4
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic [W-1:0] d,
   output logic [W-1:0] q
);

   logic [W-1:0] sync1_d, sync1_q;
   logic [W-1:0] sync2_d, sync2_q;

   always_comb begin
      sync1_d = d;
      sync2_d = sync1_q;
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         sync1_q <= '0;
         sync2_q <= '0;
      end else begin
         sync1_q <= sync1_d;
         sync2_q <= sync2_d;
      end
   end

   assign q = sync2_q;

endmodule

// File: rtl/led_mode_sw_cond.sv
// Switch conditioner: synchronise, debounce and commit the mode code, and
// produce the phase-aligned single-cycle pattern step enable.
module led_mode_sw_cond
   import led_pkg::*;
#(
   parameter int              SW_W            = SW_W_DEF,
   parameter int              DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF,
   parameter int              TICK_DIV        = TICK_DIV_DEF,
   parameter logic [SW_W-1:0] PAUSE_CODE      = SW_W'(MODE_CLEAR)
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic [SW_W-1:0] sw,
   output logic [SW_W-1:0] mode,
   output logic            mode_chg,
   output logic            step,
   output logic            settling
);

   localparam int DEB_W  = cnt_w(DEBOUNCE_CYCLES);
   localparam int TICK_W = cnt_w(TICK_DIV);
   localparam logic [DEB_W-1:0]  DEB_LAST  = DEB_W'(DEBOUNCE_CYCLES - 1);
   localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(TICK_DIV - 1);

   logic [SW_W-1:0]   sync2;

   deb_state_e        state_d, state_q;
   logic [SW_W-1:0]   cand_d, cand_q;
   logic [DEB_W-1:0]  deb_cnt_d, deb_cnt_q;
   logic [SW_W-1:0]   mode_d, mode_q;
   logic              mode_chg_d, mode_chg_q;
   logic              settling_d, settling_q;
   logic [TICK_W-1:0] tick_cnt_d, tick_cnt_q;
   logic              step_d, step_q;
   logic              commit;

   sync_2ff #(
      .W (SW_W)
   ) u_sync (
      .clk   (clk),
      .rst_n (rst_n),
      .d     (sw),
      .q     (sync2)
   );

   // Any change of the candidate restarts qualification; a return to the
   // committed value abandons it without a commit.
   always_comb begin
      state_d   = state_q;
      cand_d    = cand_q;
      deb_cnt_d = deb_cnt_q;
      mode_d    = mode_q;
      commit    = 1'b0;
      case (state_q)
         STABLE: begin
            if (sync2 != mode_q) begin
               state_d   = SETTLING;
               cand_d    = sync2;
               deb_cnt_d = '0;
            end
         end
         SETTLING: begin
            if (sync2 == mode_q) begin
               state_d = STABLE;
            end else if (sync2 != cand_q) begin
               cand_d    = sync2;
               deb_cnt_d = '0;
            end else if (deb_cnt_q == DEB_LAST) begin
               mode_d  = cand_q;
               commit  = 1'b1;
               state_d = STABLE;
            end else begin
               deb_cnt_d = deb_cnt_q + DEB_W'(1);
            end
         end
         default: state_d = STABLE;
      endcase
      mode_chg_d = commit;
      settling_d = (state_d == SETTLING);
   end

   // A commit restarts the timebase so a new pattern's first step is aligned.
   always_comb begin
      tick_cnt_d = tick_cnt_q + TICK_W'(1);
      step_d     = 1'b0;
      if (commit) begin
         tick_cnt_d = '0;
      end else if (tick_cnt_q == TICK_LAST) begin
         tick_cnt_d = '0;
         step_d     = (mode_q != PAUSE_CODE);
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q    <= STABLE;
         cand_q     <= '0;
         deb_cnt_q  <= '0;
         mode_q     <= '0;
         mode_chg_q <= 1'b0;
         settling_q <= 1'b0;
         tick_cnt_q <= '0;
         step_q     <= 1'b0;
      end else begin
         state_q    <= state_d;
         cand_q     <= cand_d;
         deb_cnt_q  <= deb_cnt_d;
         mode_q     <= mode_d;
         mode_chg_q <= mode_chg_d;
         settling_q <= settling_d;
         tick_cnt_q <= tick_cnt_d;
         step_q     <= step_d;
      end
   end

   assign mode     = mode_q;
   assign mode_chg = mode_chg_q;
   assign step     = step_q;
   assign settling = settling_q;

endmodule
